pe_vec: RTL
===========

PE_VEC -- requirements
Module: pe_vec

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, signed operand width per lane.
REQ-002 SHALL have parameter ACC_WIDTH, default 48, signed accumulator/result width per lane.
REQ-003 SHALL have parameter LANES, default 2, number of parallel MAC lanes.
REQ-004 SHALL have parameter CNT_WIDTH, default 8, width of the beat counter and of k_len_i.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_i  in  1  input beat valid
- a_i  in  LANES*DATA_WIDTH  packed signed operands A (west)
- b_i  in  LANES*DATA_WIDTH  packed signed operands B (north)
- valid_o  out  1  forwarded beat valid
- a_o  out  LANES*DATA_WIDTH  A forwarded east
- b_o  out  LANES*DATA_WIDTH  B forwarded south
- k_len_i  in  CNT_WIDTH  beats per result; sampled on first beat
- mode_i  in  1  0 = independent lanes, 1 = cross-lane reduction; sampled on first beat
- clear_i  in  1  abort current accumulation
- res_valid_o  out  1  result available
- res_ready_i  in  1  result consumed
- res_o  out  LANES*ACC_WIDTH  packed signed results
- busy_o  out  1  accumulation in progress
- ovf_o  out  1  sticky: unconsumed result overwritten
- sat_o  out  1  sticky: saturation occurred

Function
REQ-007 SHALL register valid_i, a_i, b_i to valid_o, a_o, b_o every cycle, 1-cycle latency, independent of FSM state, clear_i and result backpressure.
REQ-008 SHALL form per-lane product p_l = a_l * b_l, signed, 2*DATA_WIDTH bits, sign-extended to ACC_WIDTH.
REQ-009 SHALL implement FSM IDLE/ACC; busy_o = 1 in ACC.
REQ-010 IDLE + valid_i: latch k_len_i (0 treated as 1) and mode_i, accumulate beat, cnt = 1; to ACC unless k = 1.
REQ-011 ACC + valid_i: accumulate, increment cnt; non-valid cycles hold state and accumulators.
REQ-012 On the k-th beat: res_o loads acc + beat contribution, accumulators clear to 0, cnt clears, FSM to IDLE; res_valid_o = 1 the next cycle.
REQ-013 Mode 0: each lane accumulates its own p_l; mode 1: lane 0 accumulates the sum of all p_l, other lanes' results are 0.
REQ-014 res_valid_o SHALL stay high until the cycle res_valid_o && res_ready_i, then drop unless a new result loads the same cycle.
REQ-015 Completion with res_valid_o = 1 and res_ready_i = 0: SHALL overwrite res_o and set ovf_o; completion with res_ready_i = 1 the same cycle: no ovf_o, res_valid_o stays 1.
REQ-016 clear_i SHALL zero accumulators and cnt and go to IDLE; clear_i wins over a same-cycle valid_i (beat forwarded, not accumulated); res_o, res_valid_o, ovf_o, sat_o unaffected.
REQ-017 ovf_o and sat_o SHALL clear only on rst.

Reset
REQ-018 rst SHALL set: FSM IDLE, accumulators 0, cnt 0, valid_o 0, a_o 0, b_o 0, res_o 0, res_valid_o 0, busy_o 0, ovf_o 0, sat_o 0.
REQ-019 rst mid-accumulation SHALL discard partial sums; the first valid beat after rst starts a new result.

Configuration
REQ-020 With PE_SATURATE_EN defined: each accumulator update SHALL clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] and set sat_o on clamp.
REQ-021 Without PE_SATURATE_EN: accumulation SHALL wrap modulo 2^ACC_WIDTH; sat_o tied 0.

Verification
REQ-022 Mode 0, k=3, lane0 a=2,b=3, lane1 a=-1,b=5, 3 consecutive beats -> 1 cycle after 3rd beat res_valid_o=1, res = {lane0 18, lane1 -15}.
REQ-023 Mode 1, k=2, beats lane0 2*3, lane1 4*5 -> lane0 52, lane1 0.
REQ-024 res_ready_i=0, k=1, beats 1*1 then 7*1 -> res lane0 7, ovf_o=1; raise res_ready_i -> res_valid_o drops next cycle.
REQ-025 k=4, 2 beats of 5*5, clear_i, then 4 beats of 1*1 -> res lane0 4; valid_o/a_o/b_o mirror all 6 beats, 1 cycle late.
REQ-026 ACC_WIDTH=32, k=4, a=b=-32768 -> with PE_SATURATE_EN res lane0 2147483647, sat_o=1; without it res lane0 0, sat_o=0.
REQ-027 rst after 2 of 3 beats, then 3 beats of 2*2 -> res lane0 12; all outputs 0 in the cycle after rst.

Source files
------------

// File: rtl/pe_vec_if.sv
// Bus bundle for the pe_vec systolic MAC element: forwarded operand stream,
// per-result control and the result handshake. The slave modport is the PE side.
interface pe_vec_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 48,
  parameter int LANES      = 2,
  parameter int CNT_WIDTH  = 8
) ();

  logic                          valid_i;
  logic [LANES*DATA_WIDTH-1:0]   a_i;
  logic [LANES*DATA_WIDTH-1:0]   b_i;
  logic                          valid_o;
  logic [LANES*DATA_WIDTH-1:0]   a_o;
  logic [LANES*DATA_WIDTH-1:0]   b_o;
  logic [CNT_WIDTH-1:0]          k_len_i;
  logic                          mode_i;
  logic                          clear_i;
  logic                          res_valid_o;
  logic                          res_ready_i;
  logic [LANES*ACC_WIDTH-1:0]    res_o;
  logic                          busy_o;
  logic                          ovf_o;
  logic                          sat_o;

  modport master (
    output valid_i, a_i, b_i, k_len_i, mode_i, clear_i, res_ready_i,
    input  valid_o, a_o, b_o, res_valid_o, res_o, busy_o, ovf_o, sat_o
  );

  modport slave (
    input  valid_i, a_i, b_i, k_len_i, mode_i, clear_i, res_ready_i,
    output valid_o, a_o, b_o, res_valid_o, res_o, busy_o, ovf_o, sat_o
  );

endinterface

// File: rtl/pe_vec.sv
// pe_vec: multi-lane signed MAC processing element for a systolic array.
// Operands are forwarded east/south with one cycle of latency while each lane
// accumulates k beats into a result register with a valid/ready handshake.
// Mode 0 keeps lanes independent; mode 1 reduces all lane products into lane 0.
// Optional feature macro: PE_SATURATE_EN (clamp accumulators instead of wrapping).
module pe_vec #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 48,
  parameter int LANES      = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic clk,
  input  logic rst,
  pe_vec_if.slave bus
);

  typedef enum logic {IDLE, ACC} state_t;

  state_t state, state_next;

  logic signed [ACC_WIDTH-1:0] acc     [LANES];
  logic signed [ACC_WIDTH-1:0] contrib [LANES];
  logic signed [ACC_WIDTH-1:0] upd     [LANES];

  logic [CNT_WIDTH-1:0]        cnt;
  logic [CNT_WIDTH-1:0]        cnt_inc;
  logic [CNT_WIDTH-1:0]        k_len;
  logic [CNT_WIDTH-1:0]        k_eff;
  logic                        mode;
  logic                        mode_eff;
  logic                        beat;
  logic                        last_beat;

  logic                        valid_q;
  logic [LANES*DATA_WIDTH-1:0] a_q;
  logic [LANES*DATA_WIDTH-1:0] b_q;
  logic [LANES*ACC_WIDTH-1:0]  res_q;
  logic                        res_valid_q;
  logic                        ovf_q;

  // Beat qualification: in IDLE the control fields come straight from the bus,
  // afterwards from the values latched on the first beat. clear_i kills the beat.
  always_comb begin
    beat      = bus.valid_i && !bus.clear_i;
    cnt_inc   = cnt + CNT_WIDTH'(1);
    k_eff     = k_len;
    mode_eff  = mode;
    if (state == IDLE) begin
      k_eff    = (bus.k_len_i == '0) ? CNT_WIDTH'(1) : bus.k_len_i;
      mode_eff = bus.mode_i;
    end
    last_beat = beat && (cnt_inc == k_eff);
  end

  // Lane products, sign-extended, and the per-lane contribution for this beat.
  always_comb begin : contrib_blk
    logic signed [DATA_WIDTH-1:0]   a_l;
    logic signed [DATA_WIDTH-1:0]   b_l;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext [LANES];
    logic signed [ACC_WIDTH-1:0]    total;
    total = '0;
    for (int l = 0; l < LANES; l++) begin
      a_l         = bus.a_i[l*DATA_WIDTH +: DATA_WIDTH];
      b_l         = bus.b_i[l*DATA_WIDTH +: DATA_WIDTH];
      prod        = a_l * b_l;
      prod_ext[l] = ACC_WIDTH'(prod);
      total       = total + prod_ext[l];
    end
    for (int l = 0; l < LANES; l++) begin
      contrib[l] = prod_ext[l];
      if (mode_eff) begin
        contrib[l] = (l == 0) ? total : '0;
      end
    end
  end

`ifdef PE_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [LANES-1:0] lane_sat;
  logic             sat_q;

  // Saturating accumulator update: one guard bit exposes signed overflow.
  always_comb begin : upd_blk
    logic signed [ACC_WIDTH:0] sum_wide;
    for (int l = 0; l < LANES; l++) begin
      sum_wide    = {acc[l][ACC_WIDTH-1], acc[l]} + {contrib[l][ACC_WIDTH-1], contrib[l]};
      upd[l]      = sum_wide[ACC_WIDTH-1:0];
      lane_sat[l] = 1'b0;
      if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]) begin
        upd[l]      = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        lane_sat[l] = 1'b1;
      end
    end
  end

  // Sticky saturation flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (beat && (|lane_sat)) begin
      sat_q <= 1'b1;
    end
  end

  assign bus.sat_o = sat_q;
`else
  // Wrapping accumulator update.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      upd[l] = acc[l] + contrib[l];
    end
  end

  assign bus.sat_o = 1'b0;
`endif

  // Next-state logic: clear aborts to IDLE, the k-th beat returns to IDLE.
  always_comb begin
    state_next = state;
    if (bus.clear_i) begin
      state_next = IDLE;
    end else if (beat) begin
      state_next = last_beat ? IDLE : ACC;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Accumulators, beat counter and the control fields latched on the first beat.
  always_ff @(posedge clk) begin
    if (rst || bus.clear_i || last_beat) begin
      for (int l = 0; l < LANES; l++) acc[l] <= '0;
      cnt <= '0;
    end else if (beat) begin
      for (int l = 0; l < LANES; l++) acc[l] <= upd[l];
      cnt <= cnt_inc;
    end
    if (rst) begin
      k_len <= '0;
      mode  <= 1'b0;
    end else if (beat && state == IDLE) begin
      k_len <= k_eff;
      mode  <= mode_eff;
    end
  end

  // Result register with valid/ready handshake and sticky overwrite flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q       <= '0;
      res_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (last_beat) begin
        for (int l = 0; l < LANES; l++) res_q[l*ACC_WIDTH +: ACC_WIDTH] <= upd[l];
        res_valid_q <= 1'b1;
        if (res_valid_q && !bus.res_ready_i) ovf_q <= 1'b1;
      end else if (res_valid_q && bus.res_ready_i) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  // Operand forwarding pipeline, independent of the accumulation state.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      valid_q <= bus.valid_i;
      a_q     <= bus.a_i;
      b_q     <= bus.b_i;
    end
  end

  assign bus.valid_o     = valid_q;
  assign bus.a_o         = a_q;
  assign bus.b_o         = b_q;
  assign bus.res_o       = res_q;
  assign bus.res_valid_o = res_valid_q;
  assign bus.ovf_o       = ovf_q;
  assign bus.busy_o      = (state == ACC);

endmodule
